pc_gen: RTL and testbench

Parametrised program-counter generator for the IF stage of the 5-stage pipeline. It holds the fetch PC and selects the next PC from sequential increment, taken branch (PC-relative), absolute jump, or return. It honours a fetch stall and raises the ID flush for every redirect. An optional return-address stack (RAS) supplies return targets without a register-file read.

---
 rtl/pc_gen.sv | 125 ++++++++++++
 tb/tb_pc_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: sequential increment, branch, jump and return.
// Define PC_RAS_EN to add a return-address stack that supplies return targets.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            stall,
  input  logic            branchFlag,
  input  logic            zeroFlag,
  input  logic            jumpFlag,
  input  logic            callFlag,
  input  logic            returnFlag,
  input  logic [XLEN-1:0] jumpAddress,
  input  logic [XLEN-1:0] branchOffset,
  input  logic [XLEN-1:0] returnAddress,
  input  logic [XLEN-1:0] linkAddress,
  output logic [XLEN-1:0] PC,
  output logic            flush_INST_CTRL_ID,
  output logic            misaligned,
  output logic            ras_empty
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] ret_target;
  logic [XLEN-1:0] target_raw;
  logic            taken, redirect;

  assign taken    = branchFlag & zeroFlag;
  assign redirect = taken | jumpFlag | returnFlag;

`ifdef PC_RAS_EN
  localparam int unsigned PtrW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
  // ptr_q is the next free slot; the top entry sits one below it
  logic [PtrW-1:0] ptr_q, ptr_d, top_idx;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            push, pop, swap;

  assign push    = jumpFlag & callFlag & ~returnFlag;
  assign pop     = returnFlag & ~(jumpFlag & callFlag);
  assign swap    = jumpFlag & callFlag & returnFlag;
  assign top_idx = ptr_q - PtrW'(1);

  assign ret_target = (cnt_q != '0) ? ras_mem_q[top_idx] : returnAddress;
  assign ras_empty  = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PtrW'(1);
      if (cnt_q != (PtrW + 1)'(RAS_DEPTH)) cnt_d = cnt_q + (PtrW + 1)'(1);
    end else if (pop && cnt_q != '0) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: count gates every read
  always_ff @(posedge CLK) begin
    if (push) begin
      ras_mem_q[ptr_q] <= linkAddress;
    end else if (swap) begin
      ras_mem_q[top_idx] <= linkAddress;
    end
  end
`else
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_ras_inputs;

  assign unused_ras_inputs = callFlag ^ (^linkAddress);
  assign ret_target        = returnAddress;
  assign ras_empty         = 1'b1;
`endif

  always_comb begin
    if (returnFlag) begin
      target_raw = ret_target;
    end else if (jumpFlag) begin
      target_raw = jumpAddress;
    end else begin
      target_raw = pc_q + branchOffset;
    end

    pc_d = pc_q + XLEN'(INC);
    if (redirect) begin
      pc_d = {target_raw[XLEN-1:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end

    misaligned_d = redirect & (|target_raw[1:0]);
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign PC                 = pc_q;
  assign misaligned         = misaligned_q;
  assign flush_INST_CTRL_ID = redirect;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; RAS scenarios run when PC_RAS_EN is defined.
module tb_pc_gen;

  logic        CLK = 1'b0;
  logic        rst;
  logic        stall, branchFlag, zeroFlag, jumpFlag, callFlag, returnFlag;
  logic [31:0] jumpAddress, branchOffset, returnAddress, linkAddress;
  logic [31:0] PC;
  logic        flush_INST_CTRL_ID, misaligned, ras_empty;

  int checks = 0;
  int errors = 0;

  pc_gen #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0000_0000),
    .INC         (4),
    .RAS_DEPTH   (4)
  ) dut (
    .CLK               (CLK),
    .rst               (rst),
    .stall             (stall),
    .branchFlag        (branchFlag),
    .zeroFlag          (zeroFlag),
    .jumpFlag          (jumpFlag),
    .callFlag          (callFlag),
    .returnFlag        (returnFlag),
    .jumpAddress       (jumpAddress),
    .branchOffset      (branchOffset),
    .returnAddress     (returnAddress),
    .linkAddress       (linkAddress),
    .PC                (PC),
    .flush_INST_CTRL_ID(flush_INST_CTRL_ID),
    .misaligned        (misaligned),
    .ras_empty         (ras_empty)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall      = 1'b0;
    branchFlag = 1'b0;
    zeroFlag   = 1'b0;
    jumpFlag   = 1'b0;
    callFlag   = 1'b0;
    returnFlag = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    idle();
    jumpFlag    = 1'b1;
    jumpAddress = addr;
    tick();
    idle();
  endtask

  task automatic call(input logic [31:0] link);
    idle();
    jumpFlag    = 1'b1;
    callFlag    = 1'b1;
    jumpAddress = 32'h0000_1000;
    linkAddress = link;
    tick();
    idle();
  endtask

  task automatic ret(input logic [31:0] raddr);
    idle();
    returnFlag    = 1'b1;
    returnAddress = raddr;
    tick();
    idle();
  endtask

  initial begin
    idle();
    jumpAddress   = '0;
    branchOffset  = '0;
    returnAddress = '0;
    linkAddress   = '0;
    rst           = 1'b0;
    #12;
    check("reset_pc", PC, 32'h0);
    check("reset_misaligned", {31'b0, misaligned}, 32'h0);
    check("reset_ras_empty", {31'b0, ras_empty}, 32'h1);
    check("reset_flush", {31'b0, flush_INST_CTRL_ID}, 32'h0);
    @(negedge CLK);
    rst = 1'b1;
    #1;
    check("first_fetch", PC, 32'h0);
    tick(); check("inc_4", PC, 32'h4);
    tick(); check("inc_8", PC, 32'h8);
    tick(); check("inc_12", PC, 32'hC);
    check("inc_flush", {31'b0, flush_INST_CTRL_ID}, 32'h0);

    stall = 1'b1;
    tick(); check("stall_hold", PC, 32'hC);
    idle();

    // Taken backward branch under stall
    jump_to(32'h100);
    check("jump_100", PC, 32'h100);
    stall        = 1'b1;
    branchFlag   = 1'b1;
    zeroFlag     = 1'b1;
    branchOffset = 32'hFFFF_FFF0;
    #1;
    check("branch_flush", {31'b0, flush_INST_CTRL_ID}, 32'h1);
    tick(); check("branch_taken", PC, 32'hF0);
    idle();

    jump_to(32'h100);
    stall        = 1'b1;
    branchFlag   = 1'b1;
    zeroFlag     = 1'b0;
    branchOffset = 32'hFFFF_FFF0;
    #1;
    check("notaken_flush", {31'b0, flush_INST_CTRL_ID}, 32'h0);
    tick(); check("notaken_hold", PC, 32'h100);
    idle();

    // Priority: return over jump over branch
    jumpFlag      = 1'b1;
    jumpAddress   = 32'h400;
    branchFlag    = 1'b1;
    zeroFlag      = 1'b1;
    returnFlag    = 1'b1;
    returnAddress = 32'h800;
    tick(); check("prio_return", PC, 32'h800);
    returnFlag = 1'b0;
    tick(); check("prio_jump", PC, 32'h400);
    idle();

    jump_to(32'h203);
    check("misal_pc", PC, 32'h200);
    check("misal_set", {31'b0, misaligned}, 32'h1);
    tick();
    check("misal_clear", {31'b0, misaligned}, 32'h0);
    check("misal_next_pc", PC, 32'h204);

    jump_to(32'hFFFF_FFFC);
    check("wrap_pre", PC, 32'hFFFF_FFFC);
    tick(); check("wrap_zero", PC, 32'h0);

`ifdef PC_RAS_EN
    call(32'h10);
    check("ras_nonempty", {31'b0, ras_empty}, 32'h0);
    call(32'h20);
    call(32'h30);
    call(32'h40);
    call(32'h50);
    ret(32'h999); check("ras_pop1", PC, 32'h50);
    ret(32'h999); check("ras_pop2", PC, 32'h40);
    ret(32'h999); check("ras_pop3", PC, 32'h30);
    check("ras_not_yet_empty", {31'b0, ras_empty}, 32'h0);
    ret(32'h999); check("ras_pop4", PC, 32'h20);
    check("ras_empty_after4", {31'b0, ras_empty}, 32'h1);
    ret(32'h999); check("ras_fallback", PC, 32'h998);
    check("ras_fallback_misal", {31'b0, misaligned}, 32'h1);

    call(32'h50);
    jumpFlag      = 1'b1;
    callFlag      = 1'b1;
    returnFlag    = 1'b1;
    jumpAddress   = 32'h1000;
    linkAddress   = 32'h60;
    returnAddress = 32'h999;
    tick(); check("ras_swap_target", PC, 32'h50);
    idle();
    check("ras_swap_count", {31'b0, ras_empty}, 32'h0);
    ret(32'h999); check("ras_swap_next", PC, 32'h60);
    check("ras_swap_empty", {31'b0, ras_empty}, 32'h1);
`else
    call(32'h10);
    check("noras_empty", {31'b0, ras_empty}, 32'h1);
    ret(32'h998); check("noras_return", PC, 32'h998);
`endif

    // Asynchronous reset between edges after two pushes
    call(32'h70);
    call(32'h74);
`ifdef PC_RAS_EN
    check("pre_reset_ras", {31'b0, ras_empty}, 32'h0);
`endif
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_pc", PC, 32'h0);
    check("async_reset_ras", {31'b0, ras_empty}, 32'h1);
    rst = 1'b1;
    #1;
    check("post_reset_hold", PC, 32'h0);
    ret(32'h700); check("post_reset_return", PC, 32'h700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
